// File: rtl/ft600_tx_arbiter.sv
// ft600_tx_arbiter: round-robin arbiter that shares the FT600 bridge TX write port among
// NUM_CH 16-bit stream requesters. Each grant emits one framed burst:
//   header  {4'hA, ch, 8'h00}
//   0..BURST_MAX payload words
//   trailer {type, ch, count}
// Trailer type 4'hE means the burst ended on req_last. 4'hC means the burst was cut at
// BURST_MAX and continues in a later burst. 4'hD means the burst was closed by the idle
// timeout.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   req_*      per-channel valid/data/last inputs; req_ready is the per-channel accept
//   tx_en/tx_in/tx_full
//              write side of the bridge TX FIFO; tx_en is never high while tx_full is high
//   grant_ch   channel that is currently granted (valid while busy)
//   busy       FSM is outside IDLE
//
// tx_en, tx_in and req_ready are decoded combinationally from registered state and the
// current tx_full/req_* inputs. This lets a word move in the same cycle it is offered.
//
// Optional feature: define FT_ARB_TIMEOUT_EN to close a DATA phase after TIMEOUT
// consecutive cycles without a transfer.
module ft600_tx_arbiter #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned BURST_MAX = 32,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      req_valid,
  input  logic [16*NUM_CH-1:0]   req_data,
  input  logic [NUM_CH-1:0]      req_last,
  output logic [NUM_CH-1:0]      req_ready,
  output logic                   tx_en,
  output logic [15:0]            tx_in,
  input  logic                   tx_full,
  output logic [3:0]             grant_ch,
  output logic                   busy
);

  localparam int unsigned DW  = 16;
  localparam int unsigned CHW = 4;
  localparam int unsigned CW  = 8;

  localparam logic [3:0] MAGIC     = 4'hA;
  localparam logic [3:0] TYPE_LAST = 4'hE;
  localparam logic [3:0] TYPE_CUT  = 4'hC;
`ifdef FT_ARB_TIMEOUT_EN
  localparam logic [3:0] TYPE_TMO  = 4'hD;
`endif

  // Reject parameter values outside the supported ranges at elaboration time.
  if (NUM_CH < 1 || NUM_CH > 16 || BURST_MAX < 1 || BURST_MAX > 255 ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("ft600_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, HEADER, DATA, TRAILER} state_t;

  state_t           state_q, state_d;
  logic [CHW-1:0]   grant_d;
  logic [CHW-1:0]   last_grant_q, last_grant_d;
  logic [3:0]       trl_type_q, trl_type_d;
  logic [CW-1:0]    count_q, count_d;
`ifdef FT_ARB_TIMEOUT_EN
  logic [CW-1:0]    idle_q, idle_d;
`endif

  logic             sel_valid;
  logic             sel_last;
  logic [DW-1:0]    sel_data;
  logic             hit_max;
  logic             found;
  logic [CHW-1:0]   pick;
  logic             xfer;

  assign busy = (state_q != IDLE);

  // Select the granted channel's request signals.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (grant_ch == CHW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[DW*i +: DW];
      end
    end
  end

  // Round-robin pick: search last_grant+1, +2, ... (mod NUM_CH) and take the first valid
  // channel found. The last granted channel is checked last, so it cannot win while
  // another channel is requesting.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (!found && req_valid[i] &&
            (i == ((int'(last_grant_q) + k) % int'(NUM_CH)))) begin
          found = 1'b1;
          pick  = CHW'(i);
        end
      end
    end
  end

  assign hit_max = ((9'(count_q) + 9'd1) == 9'(BURST_MAX));

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_ch;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    trl_type_d   = trl_type_q;
`ifdef FT_ARB_TIMEOUT_EN
    idle_d       = idle_q;
`endif
    tx_en        = 1'b0;
    tx_in        = '0;
    req_ready    = '0;
    xfer         = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          count_d = '0;
          state_d = HEADER;
        end
      end

      HEADER: begin
        if (!tx_full) begin
          tx_en   = 1'b1;
          tx_in   = {MAGIC, grant_ch, 8'h00};
          state_d = DATA;
`ifdef FT_ARB_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
      end

      DATA: begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (grant_ch == CHW'(i)) req_ready[i] = !tx_full;
        end
        xfer = sel_valid && !tx_full;
        if (xfer) begin
          tx_en   = 1'b1;
          tx_in   = sel_data;
          count_d = count_q + 8'd1;
`ifdef FT_ARB_TIMEOUT_EN
          idle_d  = '0;
`endif
          // If req_last arrives on the BURST_MAX word, the burst still counts as ended.
          if (sel_last || hit_max) begin
            state_d    = TRAILER;
            trl_type_d = sel_last ? TYPE_LAST : TYPE_CUT;
          end
        end
`ifdef FT_ARB_TIMEOUT_EN
        else begin
          idle_d = idle_q + 8'd1;
          if (idle_d == CW'(TIMEOUT)) begin
            state_d    = TRAILER;
            trl_type_d = TYPE_TMO;
          end
        end
`endif
      end

      TRAILER: begin
        if (!tx_full) begin
          tx_en        = 1'b1;
          tx_in        = {trl_type_q, grant_ch, count_q};
          last_grant_d = grant_ch;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset aborts any burst that is in progress without sending a trailer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_ch     <= '0;
      last_grant_q <= CHW'(NUM_CH - 1);
      count_q      <= '0;
      trl_type_q   <= TYPE_LAST;
`ifdef FT_ARB_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_ch     <= grant_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      trl_type_q   <= trl_type_d;
`ifdef FT_ARB_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

endmodule

// File: tb/tb_ft600_tx_arbiter.sv
// tb_ft600_tx_arbiter: directed bench for ft600_tx_arbiter.
// When the bench queues stimulus on a channel, it also pushes the framed words it expects
// to a scoreboard. Every tx_en write from the DUT pops the scoreboard and is compared.
module tb_ft600_tx_arbiter;

  localparam int NCH  = 4;
  localparam int BMAX = 4;
  localparam int TMO  = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       req_valid;
  logic [16*NCH-1:0]    req_data;
  logic [NCH-1:0]       req_last;
  logic [NCH-1:0]       req_ready;
  logic                 tx_en;
  logic [15:0]          tx_in;
  logic                 tx_full;
  logic [3:0]           grant_ch;
  logic                 busy;

  int                   checks   = 0;
  int                   failures = 0;
  int                   busy_cnt = 0;
  logic                 last_en  = 1'b0;
  logic [NCH-1:0]       xfer;
  logic [15:0]          exp_q[$];
  logic [16:0]          src_mem [NCH][64];
  int                   src_wr [NCH];
  int                   src_rd [NCH];

  always #5 clk = ~clk;

  ft600_tx_arbiter #(.NUM_CH(NCH), .BURST_MAX(BMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_en(tx_en), .tx_in(tx_in), .tx_full(tx_full),
    .grant_ch(grant_ch), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Put the head of each channel's source queue onto the request inputs.
  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      if (src_rd[i] < src_wr[i]) begin
        req_valid[i]         = 1'b1;
        req_data[16*i +: 16] = src_mem[i][src_rd[i]][15:0];
        req_last[i]          = src_mem[i][src_rd[i]][16];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[16*i +: 16] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic push_src(input int ch, input int n, input bit last, input logic [15:0] base);
    for (int j = 0; j < n; j++) begin
      src_mem[ch][src_wr[ch]] = {(last && (j == n - 1)), 16'(base + 16'(j))};
      src_wr[ch]++;
    end
    drive();
  endtask

  // Model of the burst framing: split the stream into chunks of at most BMAX words.
  task automatic expect_stream(input int ch, input int n, input bit last, input logic [15:0] base);
    int rem;
    int idx;
    int k;
    rem = n;
    idx = 0;
    while (rem > 0) begin
      k = (rem < BMAX) ? rem : BMAX;
      exp_q.push_back({4'hA, 4'(ch), 8'h00});
      for (int j = 0; j < k; j++) exp_q.push_back(16'(base + 16'(idx + j)));
      idx += k;
      rem -= k;
      if (rem == 0 && !last) break;
      exp_q.push_back({((rem == 0) ? 4'hE : 4'hC), 4'(ch), 8'(k)});
    end
  endtask

  task automatic send(input int ch, input int n, input bit last, input logic [15:0] base);
    expect_stream(ch, n, last, base);
    push_src(ch, n, last, base);
  endtask

  // One clock: sample outputs at the falling edge, then update inputs just after the rising edge.
  task automatic step();
    logic [15:0] e;
    @(negedge clk);
    last_en = tx_en;
    if (busy) busy_cnt++;
    if (tx_full) begin
      chk("en_while_full", 32'(tx_en), 32'd0);
      chk("rdy_while_full", 32'(req_ready), 32'd0);
    end
    if (tx_en) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_in", 32'(tx_in), 32'(e));
      end
    end
    xfer = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) if (xfer[i]) src_rd[i]++;
    drive();
  endtask

  task automatic drain(input string tag, input int max_steps);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_steps) begin
      step();
      n++;
    end
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    rst       = 1'b1;
    tx_full   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    #1;
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant_ch), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // All four channels request one word each, and ch0 has a second packet waiting.
    send(0, 1, 1'b1, 16'h2000);
    send(1, 1, 1'b1, 16'h2100);
    send(2, 1, 1'b1, 16'h2200);
    send(3, 1, 1'b1, 16'h2300);
    send(0, 1, 1'b1, 16'h2010);
    drain("rr", 60);

    // Ch1 only: 3 words, last on the 3rd word; expect the frame to occupy 5 busy cycles.
    send(1, 3, 1'b1, 16'h0D00);
    busy_cnt = 0;
    repeat (2) step();
    chk("grant_ch1", 32'(grant_ch), 32'd1);
    repeat (6) step();
    chk("busy_cycles", 32'(busy_cnt), 32'd5);
    drain("single", 20);

    // BURST_MAX split: 6 words on ch2 become a cut burst followed by an ended burst.
    send(2, 6, 1'b1, 16'h3000);
    drain("split", 40);

    // Back-pressure applied in the HEADER, DATA and TRAILER states.
    for (int ph = 1; ph <= 5; ph += 2) begin
      send(1, 3, 1'b1, 16'h4000 + 16'(ph * 16));
      repeat (ph) step();
      tx_full = 1'b1;
      repeat (5) step();
      tx_full = 1'b0;
      step();
      chk("resume", 32'(last_en), 32'd1);
      drain("stall", 30);
    end

    // Reset mid-DATA with count=2: the frame is aborted and arbitration restarts at ch0.
    push_src(2, 5, 1'b1, 16'h5000);
    exp_q.push_back(16'hA200);
    exp_q.push_back(16'h5000);
    exp_q.push_back(16'h5001);
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("midrst_tx_en", 32'(tx_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < NCH; i++) src_rd[i] = src_wr[i];
    drive();
    step();
    rst = 1'b0;
    chk("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
    send(0, 1, 1'b1, 16'h5100);
    send(3, 1, 1'b1, 16'h5300);
    drain("after_rst", 30);

    // Ch3 sends one word without last and then goes idle.
    send(3, 1, 1'b0, 16'h6000);
`ifdef FT_ARB_TIMEOUT_EN
    exp_q.push_back(16'hD301);
    drain("timeout", 60);
`else
    repeat (30) step();
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_grant", 32'(grant_ch), 32'd3);
    chk("hold_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
